// File: rtl/clock_ctrl_if.sv
// Button/tick inputs and time/status outputs of the time-keeping controller.
// The master side drives ticks and buttons; the slave side is clock_ctrl itself.
interface clock_ctrl_if;
    logic       tick_i;
    logic       mode_i;
    logic       inc_i;
    logic [4:0] hours_o;
    logic [5:0] minutes_o;
    logic [5:0] seconds_o;
    logic [1:0] state_o;
    logic       blink_o;

    modport master (
        output tick_i, mode_i, inc_i,
        input  hours_o, minutes_o, seconds_o, state_o, blink_o
    );

    modport slave (
        input  tick_i, mode_i, inc_i,
        output hours_o, minutes_o, seconds_o, state_o, blink_o
    );
endinterface

// File: rtl/clock_ctrl.sv
// Time-keeping controller: advances hh:mm:ss on the 1 Hz tick in RUN and lets
// the user edit hours/minutes through a mode/increment button state machine.
module clock_ctrl #(
    parameter int MAX_HOUR = 23
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    clock_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_e;

    localparam logic [4:0] HOUR_LAST = 5'(MAX_HOUR);
    localparam logic [5:0] MS_LAST   = 6'd59;

    state_e     state_q, state_d;
    logic [4:0] hours_q, hours_d;
    logic [5:0] minutes_q, minutes_d;
    logic [5:0] seconds_q, seconds_d;
    logic       blink_q, blink_d;
    logic       mode_prev_q, inc_prev_q;
    logic       mode_ev, inc_ev;
    logic       sec_last, min_last, hour_last;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= RUN;
            hours_q     <= '0;
            minutes_q   <= '0;
            seconds_q   <= '0;
            blink_q     <= 1'b0;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            blink_q     <= blink_d;
            mode_prev_q <= bus.mode_i;
            inc_prev_q  <= bus.inc_i;
        end
    end

    always_comb begin
        // A mode press in the same cycle swallows any inc press.
        mode_ev   = bus.mode_i & ~mode_prev_q;
        inc_ev    = bus.inc_i & ~inc_prev_q & ~mode_ev;
        sec_last  = (seconds_q == MS_LAST);
        min_last  = (minutes_q == MS_LAST);
        hour_last = (hours_q == HOUR_LAST);

        state_d   = state_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        blink_d   = blink_q;

        case (state_q)
            RUN: begin
                blink_d = 1'b0;
                if (bus.tick_i) begin
                    seconds_d = sec_last ? '0 : seconds_q + 6'd1;
                    if (sec_last)
                        minutes_d = min_last ? '0 : minutes_q + 6'd1;
                    if (sec_last && min_last)
                        hours_d = hour_last ? '0 : hours_q + 5'd1;
                end
                if (mode_ev) begin
                    state_d = SET_HOUR;
                    blink_d = 1'b1;
                end
            end
            SET_HOUR: begin
                if (mode_ev) begin
                    state_d = SET_MIN;
                    blink_d = 1'b1;
                end else begin
                    if (inc_ev)
                        hours_d = hour_last ? '0 : hours_q + 5'd1;
                    if (bus.tick_i)
                        blink_d = ~blink_q;
                end
            end
            SET_MIN: begin
                if (mode_ev) begin
                    // Leaving edit mode restarts the minute from :00.
                    state_d   = RUN;
                    seconds_d = '0;
                    blink_d   = 1'b0;
                end else begin
                    if (inc_ev)
                        minutes_d = min_last ? '0 : minutes_q + 6'd1;
                    if (bus.tick_i)
                        blink_d = ~blink_q;
                end
            end
            default: begin
                state_d = RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    assign bus.hours_o   = hours_q;
    assign bus.minutes_o = minutes_q;
    assign bus.seconds_o = seconds_q;
    assign bus.state_o   = state_q;
    assign bus.blink_o   = blink_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed self-checking bench for clock_ctrl: counting, carry chain, set mode,
// blink, simultaneous events and asynchronous reset.
module tb_clock_ctrl;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    clock_ctrl_if bus();

    clock_ctrl #(.MAX_HOUR(23)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1 time unit after a rising edge and are sampled by the next one.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        bus.tick_i = 1'b1;
        repeat (n) step();
        bus.tick_i = 1'b0;
    endtask

    task automatic press_mode();
        bus.mode_i = 1'b1;
        step();
        bus.mode_i = 1'b0;
        step();
    endtask

    task automatic press_inc(input int n);
        repeat (n) begin
            bus.inc_i = 1'b1;
            step();
            bus.inc_i = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        bus.tick_i = 1'b0;
        bus.mode_i = 1'b0;
        bus.inc_i  = 1'b0;
        #1 rstn_i = 1'b0;
        step();
        step();
        n_checks++;
        if ({bus.hours_o, bus.minutes_o, bus.seconds_o} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_time: got %0d:%0d:%0d expected 0:0:0",
                     bus.hours_o, bus.minutes_o, bus.seconds_o);
        end
        n_checks++;
        if ({bus.state_o, bus.blink_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state: got state=%b blink=%b expected 00/0", bus.state_o, bus.blink_o);
        end
        rstn_i = 1'b1;
        step();
    endtask

    task automatic test_count();
        ticks(1);
        n_checks++;
        if ({bus.hours_o, bus.minutes_o, bus.seconds_o} !== {5'd0, 6'd0, 6'd1}) begin
            n_fail++;
            $display("FAIL count_first: got %0d:%0d:%0d expected 0:0:1",
                     bus.hours_o, bus.minutes_o, bus.seconds_o);
        end
        ticks(60);
        n_checks++;
        if ({bus.hours_o, bus.minutes_o, bus.seconds_o} !== {5'd0, 6'd1, 6'd1}) begin
            n_fail++;
            $display("FAIL count_61: got %0d:%0d:%0d expected 0:1:1",
                     bus.hours_o, bus.minutes_o, bus.seconds_o);
        end
        n_checks++;
        if ({bus.state_o, bus.blink_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL count_state: got state=%b blink=%b expected 00/0", bus.state_o, bus.blink_o);
        end
    endtask

    task automatic test_set_mode();
        press_mode();
        n_checks++;
        if ({bus.state_o, bus.blink_o} !== 3'b011) begin
            n_fail++;
            $display("FAIL set_enter_hour: got state=%b blink=%b expected 01/1", bus.state_o, bus.blink_o);
        end
        press_inc(25);
        n_checks++;
        if ({bus.hours_o, bus.minutes_o, bus.seconds_o} !== {5'd1, 6'd1, 6'd1}) begin
            n_fail++;
            $display("FAIL set_hour_wrap: got %0d:%0d:%0d expected 1:1:1",
                     bus.hours_o, bus.minutes_o, bus.seconds_o);
        end
        press_mode();
        n_checks++;
        if ({bus.state_o, bus.blink_o} !== 3'b101) begin
            n_fail++;
            $display("FAIL set_enter_min: got state=%b blink=%b expected 10/1", bus.state_o, bus.blink_o);
        end
        press_inc(60);
        n_checks++;
        if ({bus.hours_o, bus.minutes_o, bus.seconds_o} !== {5'd1, 6'd1, 6'd1}) begin
            n_fail++;
            $display("FAIL set_min_wrap: got %0d:%0d:%0d expected 1:1:1",
                     bus.hours_o, bus.minutes_o, bus.seconds_o);
        end
        press_mode();
        n_checks++;
        if ({bus.hours_o, bus.minutes_o, bus.seconds_o, bus.state_o, bus.blink_o}
            !== {5'd1, 6'd1, 6'd0, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL set_exit: got %0d:%0d:%0d state=%b blink=%b expected 1:1:0 00/0",
                     bus.hours_o, bus.minutes_o, bus.seconds_o, bus.state_o, bus.blink_o);
        end
    endtask

    task automatic test_frozen();
        press_mode();
        for (int i = 0; i < 5; i++) begin
            ticks(1);
            n_checks++;
            if (bus.blink_o !== ((i % 2 == 0) ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL frozen_blink[%0d]: got %b expected %b", i, bus.blink_o,
                         (i % 2 == 0) ? 1'b0 : 1'b1);
            end
        end
        n_checks++;
        if ({bus.hours_o, bus.minutes_o, bus.seconds_o, bus.state_o} !== {5'd1, 6'd1, 6'd0, 2'b01}) begin
            n_fail++;
            $display("FAIL frozen_time: got %0d:%0d:%0d state=%b expected 1:1:0 01",
                     bus.hours_o, bus.minutes_o, bus.seconds_o, bus.state_o);
        end
        press_mode();
        press_mode();
    endtask

    task automatic test_wrap();
        press_mode();
        press_inc(22);
        press_mode();
        press_inc(58);
        press_mode();
        n_checks++;
        if ({bus.hours_o, bus.minutes_o, bus.seconds_o, bus.state_o} !== {5'd23, 6'd59, 6'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL wrap_set: got %0d:%0d:%0d state=%b expected 23:59:0 00",
                     bus.hours_o, bus.minutes_o, bus.seconds_o, bus.state_o);
        end
        ticks(2);
        n_checks++;
        if ({bus.hours_o, bus.minutes_o, bus.seconds_o} !== {5'd23, 6'd59, 6'd2}) begin
            n_fail++;
            $display("FAIL wrap_two: got %0d:%0d:%0d expected 23:59:2",
                     bus.hours_o, bus.minutes_o, bus.seconds_o);
        end
        ticks(57);
        n_checks++;
        if ({bus.hours_o, bus.minutes_o, bus.seconds_o} !== {5'd23, 6'd59, 6'd59}) begin
            n_fail++;
            $display("FAIL wrap_pre: got %0d:%0d:%0d expected 23:59:59",
                     bus.hours_o, bus.minutes_o, bus.seconds_o);
        end
        ticks(1);
        n_checks++;
        if ({bus.hours_o, bus.minutes_o, bus.seconds_o} !== 17'd0) begin
            n_fail++;
            $display("FAIL wrap_midnight: got %0d:%0d:%0d expected 0:0:0",
                     bus.hours_o, bus.minutes_o, bus.seconds_o);
        end
    endtask

    task automatic test_simultaneous();
        press_inc(1);
        n_checks++;
        if ({bus.hours_o, bus.minutes_o, bus.seconds_o, bus.state_o} !== 19'd0) begin
            n_fail++;
            $display("FAIL run_inc_ignored: got %0d:%0d:%0d state=%b expected 0:0:0 00",
                     bus.hours_o, bus.minutes_o, bus.seconds_o, bus.state_o);
        end
        bus.mode_i = 1'b1;
        bus.inc_i  = 1'b1;
        step();
        n_checks++;
        if ({bus.state_o, bus.hours_o, bus.blink_o} !== {2'b01, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL mode_inc_same: got state=%b hours=%0d blink=%b expected 01/0/1",
                     bus.state_o, bus.hours_o, bus.blink_o);
        end
        bus.mode_i = 1'b0;
        bus.inc_i  = 1'b0;
        step();
        press_mode();
        press_mode();
        ticks(59);
        bus.tick_i = 1'b1;
        bus.mode_i = 1'b1;
        step();
        n_checks++;
        if ({bus.hours_o, bus.minutes_o, bus.seconds_o, bus.state_o} !== {5'd0, 6'd1, 6'd0, 2'b01}) begin
            n_fail++;
            $display("FAIL tick_mode_run: got %0d:%0d:%0d state=%b expected 0:1:0 01",
                     bus.hours_o, bus.minutes_o, bus.seconds_o, bus.state_o);
        end
        bus.tick_i = 1'b0;
        bus.mode_i = 1'b0;
        step();
        press_mode();
        bus.tick_i = 1'b1;
        bus.mode_i = 1'b1;
        step();
        n_checks++;
        if ({bus.hours_o, bus.minutes_o, bus.seconds_o, bus.state_o, bus.blink_o}
            !== {5'd0, 6'd1, 6'd0, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL tick_mode_setmin: got %0d:%0d:%0d state=%b blink=%b expected 0:1:0 00/0",
                     bus.hours_o, bus.minutes_o, bus.seconds_o, bus.state_o, bus.blink_o);
        end
        bus.tick_i = 1'b0;
        bus.mode_i = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        press_mode();
        press_inc(12);
        press_mode();
        press_inc(33);
        n_checks++;
        if ({bus.hours_o, bus.minutes_o, bus.state_o} !== {5'd12, 6'd34, 2'b10}) begin
            n_fail++;
            $display("FAIL pre_reset: got %0d:%0d state=%b expected 12:34 10",
                     bus.hours_o, bus.minutes_o, bus.state_o);
        end
        #2;
        bus.mode_i = 1'b1;
        rstn_i     = 1'b0;
        #1;
        n_checks++;
        if ({bus.hours_o, bus.minutes_o, bus.seconds_o, bus.state_o, bus.blink_o} !== 20'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %0d:%0d:%0d state=%b blink=%b expected all 0",
                     bus.hours_o, bus.minutes_o, bus.seconds_o, bus.state_o, bus.blink_o);
        end
        step();
        step();
        #2 rstn_i = 1'b1;
        step();
        n_checks++;
        if ({bus.state_o, bus.blink_o} !== 3'b011) begin
            n_fail++;
            $display("FAIL release_event: got state=%b blink=%b expected 01/1", bus.state_o, bus.blink_o);
        end
        step();
        step();
        n_checks++;
        if (bus.state_o !== 2'b01) begin
            n_fail++;
            $display("FAIL held_single_event: got state=%b expected 01", bus.state_o);
        end
        bus.mode_i = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_count();
        test_set_mode();
        test_frozen();
        test_wrap();
        test_simultaneous();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
